alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests from two masters (port 0: core datapath, port 1: debug/ShowR unit) over valid/ready handshakes and grants one at a time. It drives the ALU's control and operand inputs for exactly one execute cycle, then captures result, second result and flags into registers. It returns these to the granted master through a held response handshake.

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter and sequencer for the shared 8-bit ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_result2,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_result2,
  output logic [3:0]        rsp_flags
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  logic              r_id;
  logic [OP_W-1:0]   r_alu_ctrl;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic [DATA_W-1:0] r_rsp_result2;
  logic [3:0]        r_rsp_flags;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic              r_ptr;
`endif

  logic w_sel;
  logic w_accept;

  // Only a port with req_valid high can see req_ready, so w_sel may point at an idle port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_ready = 2'b00;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    w_sel = req_valid[0] ? (req_valid[1] ? r_ptr : 1'b0) : 1'b1;
`else
    w_sel = ~req_valid[0];
`endif
    if (r_state == S_IDLE && req_valid[w_sel]) req_ready[w_sel] = 1'b1;
    w_accept = |req_ready;
  end

  // The ALU drive registers double as the latched request, and are zero outside EXEC.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= S_IDLE;
      r_id          <= 1'b0;
      r_alu_ctrl    <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_result2 <= '0;
      r_rsp_flags   <= '0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      r_ptr         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id       <= w_sel;
            r_alu_ctrl <= w_sel ? req1_op : req0_op;
            r_alu_a    <= w_sel ? req1_a  : req0_a;
            r_alu_b    <= w_sel ? req1_b  : req0_b;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result  <= alu_result;
          r_rsp_result2 <= alu_result2;
          r_rsp_flags   <= alu_flags;
          r_rsp_valid   <= 1'b1;
          r_alu_ctrl    <= '0;
          r_alu_a       <= '0;
          r_alu_b       <= '0;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            r_ptr       <= ~r_id;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_ctrl    = r_alu_ctrl;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_result2 = r_rsp_result2;
  assign rsp_flags   = r_rsp_flags;

endmodule
